// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use MSB-first shift-add into a 64-bit accumulator; divides use
// restoring shift-subtract with a 33-bit partial remainder. Divide-by-zero and
// signed overflow complete on a one-cycle path.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle '*'.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_A,
  input  logic [XLEN-1:0] op_B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  logic        r_sa, r_sb;
  logic [63:0] r_acc;
  logic [31:0] r_rem;
  logic [4:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_accept, w_a_signed, w_b_signed, w_sa, w_sb;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div_zero, w_div_ovf, w_special, w_fast, w_short;
  logic [31:0] w_special_res, w_fast_res, w_short_res;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [63:0] w_acc_nx, w_prod;
  logic [31:0] w_quot, w_remv, w_fix;

  // Operand decode at accept: signedness, magnitudes and the one-cycle cases
  always_comb begin
    w_accept      = (r_state == S_IDLE) && start && !flush;
    w_a_signed    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    w_b_signed    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    w_sa          = w_a_signed && op_A[31];
    w_sb          = w_b_signed && op_B[31];
    w_a_mag       = w_sa ? ('0 - op_A) : op_A;
    w_b_mag       = w_sb ? ('0 - op_B) : op_B;
    w_div_zero    = funct3[2] && (op_B == '0);
    w_div_ovf     = funct3[2] && !funct3[0] && (op_A == 32'h8000_0000) && (op_B == '1);
    w_special     = w_div_zero || w_div_ovf;
    w_special_res = funct3[1] ? (w_div_zero ? op_A : '0)
                              : (w_div_zero ? '1 : 32'h8000_0000);
    w_short       = w_special || w_fast;
    w_short_res   = w_special ? w_special_res : w_fast_res;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] w_fast_full;
  // Single-cycle multiply on 33-bit sign/zero-extended operands
  always_comb begin
    w_fast_full = $signed({w_sa, op_A}) * $signed({w_sb, op_B});
    w_fast      = !funct3[2];
    w_fast_res  = (funct3 == 3'd0) ? w_fast_full[31:0] : w_fast_full[63:32];
  end
`else
  // Multiplies take the iterative path in this build
  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
  end
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_rem_sh = {r_rem, r_a[r_cnt]};
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    w_rem_nx = w_ge ? 32'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[31:0];
    if (r_op[2]) w_acc_nx = {r_acc[62:0], w_ge};
    else         w_acc_nx = {r_acc[62:0], 1'b0} + (r_b[r_cnt] ? {32'h0, r_a} : 64'h0);
  end

  // Sign correction and result selection
  always_comb begin
    w_prod = (r_sa ^ r_sb) ? ('0 - r_acc) : r_acc;
    w_quot = (r_sa ^ r_sb) ? ('0 - r_acc[31:0]) : r_acc[31:0];
    w_remv = r_sa ? ('0 - r_rem) : r_rem;
    w_fix  = '0;
    unique case (r_op)
      3'd0:               w_fix = w_prod[31:0];
      3'd1, 3'd2, 3'd3:   w_fix = w_prod[63:32];
      3'd4, 3'd5:         w_fix = w_quot;
      default:            w_fix = w_remv;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_short ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)              w_next = S_IDLE;
        else if (r_cnt == 5'd0) w_next = S_FIX;
      end
      S_FIX:  w_next = flush ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Datapath registers: latch at accept, iterate in CALC, commit result in FIX
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= funct3;
          r_a   <= w_a_mag;
          r_b   <= w_b_mag;
          r_sa  <= w_sa;
          r_sb  <= w_sb;
          r_acc <= '0;
          r_rem <= '0;
          r_cnt <= 5'd31;
          if (w_short) r_result <= w_short_res;
        end
        S_CALC: begin
          r_acc <= w_acc_nx;
          if (r_op[2]) r_rem <= w_rem_nx;
          r_cnt <= r_cnt - 5'd1;
        end
        S_FIX: if (!flush) r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_A, op_B;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3(funct3),
    .op_A(op_A), .op_B(op_B), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      pa, pb;
    logic [63:0] p;
    int          ia, ib;
    ia = a;
    ib = b;
    p  = '0;
    case (f3)
      3'd0, 3'd3: p = {32'h0, a} * {32'h0, b};
      3'd1: begin pa = longint'(ia); pb = longint'(ib); p = pa * pb; end
      3'd2: begin pa = longint'(ia); pb = longint'({32'h0, b}); p = pa * pb; end
      default: ;
    endcase
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges from accept to the first cycle showing done
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 0;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    if (!f3[2] && FAST) return 0;
    return 33;
  endfunction

  // Caller is at a negedge; returns at a negedge one cycle after done
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    int k;
    bit busy_ok;
    logic [31:0] exp;
    exp = model(f3, a, b);
    start = 1'b1; funct3 = f3; op_A = a; op_B = b;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); op_A = $urandom; op_B = $urandom;
    k = 0; busy_ok = 1'b1;
    while (!done && k < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k !== exp_lat(f3, a, b)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat(f3, a, b));
    end
    n_tests++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result f3=%0d a=%h b=%h: got %h expected %h", name, f3, a, b, result, exp);
    end
    n_tests++;
    if (!busy_ok || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy during op: got %b expected 1", name, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after done: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'd0; op_A = 32'd7; op_B = 32'd3;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    start = 1'b0; rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_directed();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7/2");
    do_op(3'd5, 32'd100, 32'd7, "divu_100/7");
    do_op(3'd7, 32'd100, 32'd7, "remu_100/7");
    do_op(3'd5, 32'd5, 32'd0, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
  endtask

  task automatic test_flush();
    do_op(3'd5, 32'd100, 32'd7, "flush_pre");
    start = 1'b1; funct3 = 3'd5; op_A = 32'd1000; op_B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
      n_fail++;
      $display("FAIL flush_calc: busy=%b done=%b result=%h expected 0 0 0000000e", busy, done, result);
    end
    do_op(3'd5, 32'd1000, 32'd3, "flush_post");
    start = 1'b1; flush = 1'b1; funct3 = 3'd4; op_A = 32'd9; op_B = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int k, dones;
    logic [31:0] exp;
    exp = model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    start = 1'b1; funct3 = 3'd3; op_A = 32'hDEAD_BEEF; op_B = 32'h1234_5678;
    @(negedge clk);
    funct3 = 3'd0; op_A = 32'd1; op_B = 32'd1;
    k = 0; dones = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    if (done) dones++;
    start = 1'b0;
    n_tests++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL held_start result: got %h expected %h", result, exp);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL held_start dones: got %0d expected 1", dones);
    end
    do_op(3'd7, 32'd12345, 32'd100, "second_start");
  endtask

  task automatic test_reset_mid();
    int dones;
    start = 1'b1; funct3 = 3'd3; op_A = 32'hFFFF_0000; op_B = 32'h0001_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_mid dones: got %0d expected 0", dones);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      do_op(f3, a, b, "random");
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_A = '0; op_B = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
